change_sign_gen: RTL and testbench
==================================

Name: change_sign_gen

Overview:
- Generator counterpart of the sign-change counter. It accepts a requested transition count K and builds a WORD_SIZE-bit word with exactly K adjacent-bit sign changes.
- A change is counted at bit pairs (i, i+1), i = 0..WORD_SIZE-2. Feeding out_data into the counter returns K.
- Transitions are placed serially, one bit position per cycle. Placement is either packed (lowest positions) or pseudo-random (LFSR-driven).
- Used as a stimulus and pattern source in front of the counting path.

Parameters:
- WORD_SIZE, 64, output word width; legal range >= 4.
- CW, $clog2(WORD_SIZE), count width; local, not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  load LFSR from seed; honoured only in IDLE.
- seed  in  32  LFSR seed; value 0 is replaced by 32'h1.
- req_valid  in  1  request valid.
- req_ready  out  1  high iff state == IDLE.
- req_count  in  CW  requested transition count K.
- req_start_bit  in  1  value of out_data[0].
- req_random  in  1  1 = LFSR placement, 0 = packed placement.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accept.
- out_data  out  WORD_SIZE  generated word.
- out_count  out  CW  effective K (after saturation).
- out_sat  out  1  req_count exceeded WORD_SIZE-1.

Behaviour:
- Reset values (async, rst_n low): state IDLE, out_valid 0, out_data 0, out_count 0, out_sat 0, LFSR 32'h1. req_ready is 1 because it is decoded from state.
- States: IDLE -> BUILD -> OUT -> IDLE.
- IDLE, on req_valid & req_ready:
  - latch mode and start bit; set out_data[0] = req_start_bit;
  - r = min(req_count, WORD_SIZE-1); out_count = r; out_sat = (req_count > WORD_SIZE-1);
  - i = 0; go to BUILD.
- IDLE, seed_load high: load the LFSR from seed. If seed_load coincides with a request accept, the seed loads first; the LFSR does not advance in IDLE.
- BUILD, once per cycle for position i:
  - rem = WORD_SIZE-1-i (positions left, including this one).
  - force = (r == rem).
  - t = force | (r != 0 & (req_random ? lfsr[0] : 1)).
  - out_data[i+1] = out_data[i] ^ t; r -= t; the LFSR advances one step.
  - When i == WORD_SIZE-2, go to OUT; otherwise i++.
- Correctness invariant: r <= rem always holds, so r == 0 at exit and exactly K transitions are placed.
- OUT: out_valid = 1. out_data, out_count and out_sat are stable until out_valid & out_ready, then return to IDLE.
- Latency and throughput:
  - out_valid rises WORD_SIZE-1 cycles after the accepting edge.
  - req_ready reasserts the cycle after the output handshake; there is no same-cycle bypass.
  - Throughput is one word per WORD_SIZE+1 cycles with out_ready held high.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). It advances only in BUILD.
- Boundaries:
  - K = 0 gives a constant word equal to the start bit.
  - K = WORD_SIZE-1 gives an alternating word; every position is forced, so the result is independent of mode and seed.
  - With non-power-of-two WORD_SIZE, counts above WORD_SIZE-1 saturate and set out_sat.
- rst_n low mid-BUILD or mid-OUT: abort immediately and restore all reset values; the partial word is discarded.
- req_* inputs are ignored outside IDLE. out_ready is ignored outside OUT.

Decomposition:
- Package change_sign_pkg holds:
  - state enum (IDLE, BUILD, OUT);
  - LFSR_POLY = 32'h8020_0003;
  - LFSR_RESET = 32'h1;
  - function sat_count(count, word_size).
- One sub-module: lfsr32, with ports clk, rst_n, load, seed, step, state[31:0]. The zero-seed replacement is done inside lfsr32.

Test Plan:
- WORD_SIZE=8, packed, K=3, start=0 -> out_data 8'hFA, out_count 3, out_sat 0; out_valid exactly 7 cycles after accept.
- WORD_SIZE=8, K=7, start=1, random mode with any seed -> 8'h55. Same request with K=0 -> 8'hFF.
- WORD_SIZE=64, random mode, seed 32'hDEAD_BEEF, 1000 requests with random K and start bit -> each out_data, fed to change_sign, returns K; out_data[0] equals the start bit; the seed=0 load behaves as seed 1.
- WORD_SIZE=6, req_count 7 -> out_count 5, out_sat 1, and the word alternates from the start bit.
- Backpressure: out_ready held low 20 cycles -> out_valid and out_data stable, req_ready 0 throughout; after the handshake, req_ready is 1 on the next cycle.
- rst_n pulsed low at BUILD i=3 -> outputs are at reset values immediately; the next request completes correctly with the LFSR restarted from 32'h1.

Source files
------------

// File: rtl/change_sign_pkg.sv
// Shared types and constants for the sign-change pattern generator.
package change_sign_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBuild,
    StOut
  } state_e;

  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h1;

  function automatic int unsigned sat_count(input int unsigned count,
                                            input int unsigned word_size);
    return (count > word_size - 1) ? word_size - 1 : count;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed load; an all-zero seed would lock up, so it maps to 1.
module lfsr32
  import change_sign_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  assign w_next = {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_POLY : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LFSR_RESET;
    end else if (load) begin
      r_state <= (seed == 32'h0) ? LFSR_RESET : seed;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/change_sign_gen.sv
// Builds a WORD_SIZE-bit word with exactly K adjacent-bit sign changes, one bit position per cycle.
module change_sign_gen
  import change_sign_pkg::*;
#(
  parameter  int unsigned WORD_SIZE = 64,
  localparam int unsigned CW        = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CW-1:0]        req_count,
  input  logic                 req_start_bit,
  input  logic                 req_random,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 out_sat
);

  state_e               r_state;
  logic                 r_random;
  logic [CW-1:0]        r_left;
  logic [CW-1:0]        r_idx;
  logic [WORD_SIZE-1:0] r_data;
  logic [CW-1:0]        r_count;
  logic                 r_sat;
  logic                 r_valid;

  logic [31:0]   w_lfsr;
  logic          w_unused_lfsr;
  logic          w_idle;
  logic [CW-1:0] w_sat_cnt;
  logic          w_sat;
  logic [CW-1:0] w_rem;
  logic          w_force;
  logic          w_t;
  logic [CW-1:0] w_idx_nxt;
  logic          w_last;

  assign w_idle        = (r_state == StIdle);
  assign w_unused_lfsr = ^w_lfsr[31:1];

  // Seed load takes priority in IDLE; the LFSR only steps while building.
  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load & w_idle),
    .seed  (seed),
    .step  (r_state == StBuild),
    .state (w_lfsr)
  );

  assign w_sat_cnt = CW'(sat_count(32'(req_count), WORD_SIZE));
  assign w_sat     = 32'(req_count) > (WORD_SIZE - 1);

  // Forcing a transition whenever the remaining count equals the positions left keeps r <= rem.
  assign w_rem     = CW'(WORD_SIZE - 1) - r_idx;
  assign w_force   = (r_left == w_rem);
  assign w_t       = w_force | ((r_left != '0) & (r_random ? w_lfsr[0] : 1'b1));
  assign w_idx_nxt = r_idx + CW'(1);
  assign w_last    = (r_idx == CW'(WORD_SIZE - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_random <= 1'b0;
      r_left   <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_count  <= '0;
      r_sat    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_random <= req_random;
            r_data   <= {{(WORD_SIZE - 1){1'b0}}, req_start_bit};
            r_left   <= w_sat_cnt;
            r_count  <= w_sat_cnt;
            r_sat    <= w_sat;
            r_idx    <= '0;
            r_state  <= StBuild;
          end
        end
        StBuild: begin
          r_data[w_idx_nxt] <= r_data[r_idx] ^ w_t;
          r_left            <= r_left - CW'(w_t);
          if (w_last) begin
            r_valid <= 1'b1;
            r_state <= StOut;
          end else begin
            r_idx <= w_idx_nxt;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_count = r_count;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_change_sign_gen.sv
// Scoreboard bench for change_sign_gen at WORD_SIZE 8, 64 and 6.
module tb_change_sign_gen;

  typedef struct {
    logic [63:0] data;
    int          count;
    bit          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q8[$];
  exp_t q64[$];
  exp_t q6[$];
  logic [31:0] m_lfsr64;

  // WORD_SIZE = 8
  logic        sl8, rv8, rr8, rs8, rnd8, ov8, ordy8, osat8;
  logic [31:0] seed8;
  logic [2:0]  rc8, oc8;
  logic [7:0]  od8;
  // WORD_SIZE = 64
  logic        sl64, rv64, rr64, rs64, rnd64, ov64, ordy64, osat64;
  logic [31:0] seed64;
  logic [5:0]  rc64, oc64;
  logic [63:0] od64;
  // WORD_SIZE = 6
  logic        sl6, rv6, rr6, rs6, rnd6, ov6, ordy6, osat6;
  logic [31:0] seed6;
  logic [2:0]  rc6, oc6;
  logic [5:0]  od6;

  change_sign_gen #(.WORD_SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .seed_load(sl8), .seed(seed8), .req_valid(rv8),
    .req_ready(rr8), .req_count(rc8), .req_start_bit(rs8), .req_random(rnd8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_count(oc8), .out_sat(osat8)
  );

  change_sign_gen #(.WORD_SIZE(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .seed_load(sl64), .seed(seed64), .req_valid(rv64),
    .req_ready(rr64), .req_count(rc64), .req_start_bit(rs64), .req_random(rnd64),
    .out_valid(ov64), .out_ready(ordy64), .out_data(od64), .out_count(oc64), .out_sat(osat64)
  );

  change_sign_gen #(.WORD_SIZE(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .seed_load(sl6), .seed(seed6), .req_valid(rv6),
    .req_ready(rr6), .req_count(rc6), .req_start_bit(rs6), .req_random(rnd6),
    .out_valid(ov6), .out_ready(ordy6), .out_data(od6), .out_count(oc6), .out_sat(osat6)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_gen(input int w, input int k, input bit start, input bit rnd,
                           inout logic [31:0] lfsr, output logic [63:0] word);
    int r;
    bit t;
    r       = (k > w - 1) ? w - 1 : k;
    word    = '0;
    word[0] = start;
    for (int i = 0; i < w - 1; i++) begin
      t           = (r == w - 1 - i) || (r != 0 && (rnd ? lfsr[0] : 1'b1));
      word[i + 1] = word[i] ^ t;
      r           = r - int'(t);
      lfsr        = lfsr_next(lfsr);
    end
  endtask

  function automatic int count_changes(input logic [63:0] word, input int w);
    int n = 0;
    for (int i = 0; i < w - 1; i++) n += int'(word[i] ^ word[i + 1]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input int k, input bit start, input bit rnd);
    rc8 = 3'(k); rs8 = start; rnd8 = rnd; rv8 = 1'b1;
    tick();
    rv8 = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake8();
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks += 5;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b want 0", ov8); end
    if (od8 !== 8'h00) begin n_fail++; $display("FAIL reset_data8: got %h want 00", od8); end
    if (oc8 !== 3'd0 || osat8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt8: got %0d/%b want 0/0", oc8, osat8);
    end
    if (rr8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready8: got %b want 1", rr8); end
    if (od64 !== 64'h0 || ov64 !== 1'b0 || rr64 !== 1'b1 || od6 !== 6'h0) begin
      n_fail++; $display("FAIL reset_others: got %h/%b/%b/%h want 0/0/1/0", od64, ov64, rr64, od6);
    end
    #1 rst_n = 1'b1;
    m_lfsr64 = 32'h1;
    tick();
  endtask

  task automatic test_packed_latency();
    exp_t e;
    int   cyc;
    q8.push_back('{data: 64'hFA, count: 3, sat: 1'b0});
    send8(3, 1'b0, 1'b0);
    wait8(cyc);
    e = q8.pop_front();
    n_checks += 4;
    if (cyc != 7) begin n_fail++; $display("FAIL latency8: got %0d cycles want 7", cyc); end
    if (od8 !== e.data[7:0]) begin n_fail++; $display("FAIL packed_data: got %h want %h", od8, e.data[7:0]); end
    if (int'(oc8) != e.count || osat8 !== e.sat) begin
      n_fail++; $display("FAIL packed_cnt: got %0d/%b want %0d/%b", oc8, osat8, e.count, e.sat);
    end
    handshake8();
    if (ov8 !== 1'b0 || rr8 !== 1'b1) begin
      n_fail++; $display("FAIL packed_release: got valid %b ready %b want 0/1", ov8, rr8);
    end
  endtask

  task automatic test_boundaries8();
    int   ks[3]  = '{7, 0, 0};
    bit   st[3]  = '{1'b1, 1'b1, 1'b0};
    bit   rn[3]  = '{1'b1, 1'b1, 1'b0};
    logic [7:0] ex[3] = '{8'h55, 8'hFF, 8'h00};
    exp_t e;
    int   cyc;
    seed8 = 32'h1234_5678; sl8 = 1'b1;
    tick();
    sl8 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      q8.push_back('{data: {56'h0, ex[n]}, count: ks[n], sat: 1'b0});
      send8(ks[n], st[n], rn[n]);
      wait8(cyc);
      e = q8.pop_front();
      n_checks += 2;
      if (od8 !== e.data[7:0] || ov8 !== 1'b1) begin
        n_fail++; $display("FAIL boundary_data[%0d]: got %h valid %b want %h", n, od8, ov8, e.data[7:0]);
      end
      if (int'(oc8) != e.count || osat8 !== e.sat) begin
        n_fail++; $display("FAIL boundary_cnt[%0d]: got %0d/%b want %0d/0", n, oc8, osat8, e.count);
      end
      handshake8();
    end
  endtask

  task automatic test_saturation6();
    int   ks[5]  = '{7, 7, 6, 5, 0};
    bit   st[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit   rn[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] ex[5] = '{6'h2A, 6'h15, 6'h15, 6'h2A, 6'h3F};
    int   ec[5]  = '{5, 5, 5, 5, 0};
    bit   es[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t e;
    int   cyc;
    for (int n = 0; n < 5; n++) begin
      q6.push_back('{data: {58'h0, ex[n]}, count: ec[n], sat: es[n]});
      rc6 = 3'(ks[n]); rs6 = st[n]; rnd6 = rn[n]; rv6 = 1'b1;
      tick();
      rv6 = 1'b0;
      cyc = 0;
      while (!ov6 && cyc < 200) begin tick(); cyc++; end
      e = q6.pop_front();
      n_checks += 3;
      if (od6 !== e.data[5:0] || ov6 !== 1'b1) begin
        n_fail++; $display("FAIL sat6_data[%0d]: got %h valid %b want %h", n, od6, ov6, e.data[5:0]);
      end
      if (int'(oc6) != e.count) begin
        n_fail++; $display("FAIL sat6_count[%0d]: got %0d want %0d", n, oc6, e.count);
      end
      if (osat6 !== e.sat) begin
        n_fail++; $display("FAIL sat6_flag[%0d]: got %b want %b", n, osat6, e.sat);
      end
      ordy6 = 1'b1;
      tick();
      ordy6 = 1'b0;
    end
  endtask

  task automatic run64(input int k, input bit start, input bit load, input logic [31:0] sd,
                       input int tag);
    exp_t        e;
    logic [63:0] w;
    int          cyc;
    if (load) m_lfsr64 = (sd == 32'h0) ? 32'h1 : sd;
    model_gen(64, k, start, 1'b1, m_lfsr64, w);
    q64.push_back('{data: w, count: k, sat: 1'b0});
    rc64 = 6'(k); rs64 = start; rnd64 = 1'b1; rv64 = 1'b1;
    sl64 = load; seed64 = sd;
    tick();
    rv64 = 1'b0; sl64 = 1'b0;
    cyc = 0;
    while (!ov64 && cyc < 200) begin tick(); cyc++; end
    e = q64.pop_front();
    n_checks += 4;
    if (od64 !== e.data || ov64 !== 1'b1) begin
      n_fail++; $display("FAIL rand64_data[%0d]: got %h valid %b want %h", tag, od64, ov64, e.data);
    end
    if (count_changes(od64, 64) != e.count) begin
      n_fail++; $display("FAIL rand64_changes[%0d]: got %0d want %0d", tag, count_changes(od64, 64), e.count);
    end
    if (od64[0] !== start) begin
      n_fail++; $display("FAIL rand64_start[%0d]: got %b want %b", tag, od64[0], start);
    end
    if (int'(oc64) != e.count || osat64 !== 1'b0) begin
      n_fail++; $display("FAIL rand64_cnt[%0d]: got %0d/%b want %0d/0", tag, oc64, osat64, e.count);
    end
    tick();
  endtask

  task automatic test_random64();
    seed64 = 32'hDEAD_BEEF; sl64 = 1'b1;
    tick();
    sl64 = 1'b0;
    m_lfsr64 = 32'hDEAD_BEEF;
    ordy64 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      run64(int'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 1'b0, 32'h0, n);
    end
    // Zero seed coinciding with an accept: seed loads first and is treated as 1.
    run64(20, 1'b1, 1'b1, 32'h0, 1000);
    run64(37, 1'b0, 1'b0, 32'h0, 1001);
    ordy64 = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc;
    q8.push_back('{data: 64'hEA, count: 5, sat: 1'b0});
    send8(5, 1'b0, 1'b0);
    wait8(cyc);
    e = q8.pop_front();
    n_checks++;
    if (od8 !== e.data[7:0] || ov8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_data: got %h valid %b want %h", od8, ov8, e.data[7:0]);
    end
    rc8 = 3'd1; rs8 = 1'b1; rv8 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (ov8 !== 1'b1 || od8 !== e.data[7:0] || rr8 !== 1'b0 || int'(oc8) != e.count) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid %b data %h ready %b cnt %0d want 1/%h/0/%0d",
                 c, ov8, od8, rr8, oc8, e.data[7:0], e.count);
      end
    end
    rv8 = 1'b0;
    handshake8();
    n_checks++;
    if (ov8 !== 1'b0 || rr8 !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid %b ready %b want 0/1", ov8, rr8);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acc = 0;
    int   outs = 0;
    int   t_out[3] = '{0, 0, 0};
    bit   acc_now;
    for (int n = 0; n < 3; n++) q8.push_back('{data: 64'hFD, count: 2, sat: 1'b0});
    rc8 = 3'd2; rs8 = 1'b1; rnd8 = 1'b0; rv8 = 1'b1; ordy8 = 1'b1;
    for (int c = 0; c < 60 && outs < 3; c++) begin
      acc_now = rv8 && rr8;
      tick();
      if (acc_now) begin
        acc++;
        if (acc == 3) rv8 = 1'b0;
      end
      if (ov8) begin
        e = q8.pop_front();
        t_out[outs] = c;
        outs++;
        n_checks++;
        if (od8 !== e.data[7:0]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", outs, od8, e.data[7:0]);
        end
      end
    end
    rv8 = 1'b0;
    tick();
    ordy8 = 1'b0;
    n_checks += 3;
    if (outs != 3) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 3", outs); end
    if (t_out[1] - t_out[0] != 9 || t_out[2] - t_out[1] != 9) begin
      n_fail++; $display("FAIL b2b_period: got %0d,%0d want 9,9", t_out[1] - t_out[0], t_out[2] - t_out[1]);
    end
    if (rr8 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got ready %b want 1", rr8); end
  endtask

  task automatic test_reset_mid_build();
    exp_t        e;
    logic [31:0] l;
    logic [63:0] w;
    int          cyc;
    send8(4, 1'b1, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (ov8 !== 1'b0 || od8 !== 8'h00 || oc8 !== 3'd0 || osat8 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b/%h/%0d/%b want 0/00/0/0", ov8, od8, oc8, osat8);
    end
    if (rr8 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", rr8); end
    #1 rst_n = 1'b1;
    m_lfsr64 = 32'h1;
    tick();
    l = 32'h1;
    model_gen(8, 6, 1'b0, 1'b1, l, w);
    q8.push_back('{data: w, count: 6, sat: 1'b0});
    send8(6, 1'b0, 1'b1);
    wait8(cyc);
    e = q8.pop_front();
    n_checks += 2;
    if (od8 !== e.data[7:0] || ov8 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_next: got %h valid %b want %h", od8, ov8, e.data[7:0]);
    end
    if (count_changes({56'h0, od8}, 8) != 6 || int'(oc8) != 6) begin
      n_fail++; $display("FAIL midrst_changes: got %0d/%0d want 6/6", count_changes({56'h0, od8}, 8), oc8);
    end
    handshake8();
  endtask

  initial begin
    {sl8, rv8, rs8, rnd8, ordy8, seed8, rc8} = '0;
    {sl64, rv64, rs64, rnd64, ordy64, seed64, rc64} = '0;
    {sl6, rv6, rs6, rnd6, ordy6, seed6, rc6} = '0;
    test_reset();
    test_packed_latency();
    test_boundaries8();
    test_saturation6();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_build();
    test_random64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
